// File: rtl/out_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble) for the CPU out path.
// Converts a captured value one bit per clock and drives four saturated BCD digits.
module out_bcd_seq #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic [3:0]       mil,
   output logic [3:0]       cent,
   output logic [3:0]       dez,
   output logic [3:0]       uni,
   output logic             ovf,
   output logic             neg
);

   // ceil(WIDTH*log10(2)) decimal digits; at least five so an overflow digit always exists
   localparam int NDIG  = (WIDTH * 30103 + 99999) / 100000;
   localparam int ADIG  = (NDIG > 4) ? NDIG : 5;
   localparam int ACC_W = 4 * ADIG;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   sreg;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               sign_lat;
   logic [ACC_W-1:0]   acc_adj;
   logic [ACC_W-1:0]   acc_shift;
   logic [WIDTH-1:0]   sreg_shift;

   // Magnitude is formed at WIDTH+1 bits so the most negative value negates exactly.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      logic signed [WIDTH:0] ext;
      ext = $signed({SIGNED && v[WIDTH-1], v});
      if (ext[WIDTH]) ext = -ext;
      return ext[WIDTH-1:0];
   endfunction

   function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
      logic [ACC_W-1:0] r;
      r = a;
      for (int d = 0; d < ADIG; d++) begin
         if (a[4*d +: 4] > 4'd4) r[4*d +: 4] = a[4*d +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Returns {ovf, four digits}; anything above 9999 clamps to all nines.
   function automatic logic [16:0] saturate(input logic [ACC_W-1:0] a);
      if (|a[ACC_W-1:16]) return {1'b1, 16'h9999};
      return {1'b0, a[15:0]};
   endfunction

   assign acc_adj    = add3(acc);
   assign acc_shift  = {acc_adj[ACC_W-2:0], sreg[WIDTH-1]};
   assign sreg_shift = {sreg[WIDTH-2:0], 1'b0};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SHIFT;
         S_SHIFT: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sreg     <= '0;
         acc      <= '0;
         cnt      <= '0;
         sign_lat <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         neg      <= 1'b0;
         mil      <= '0;
         cent     <= '0;
         dez      <= '0;
         uni      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  sreg     <= magnitude(value);
                  acc      <= '0;
                  cnt      <= '0;
                  sign_lat <= SIGNED && value[WIDTH-1];
                  busy     <= 1'b1;
               end
            end
            S_SHIFT: begin
               acc  <= acc_shift;
               sreg <= sreg_shift;
               cnt  <= cnt + CNT_W'(1);
            end
            S_DONE: begin
               {ovf, mil, cent, dez, uni} <= saturate(acc);
               neg  <= sign_lat;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
